// File: rtl/inert_rdr.sv
`default_nettype none
// inert_rdr: brings up the IMU over the SPI master, then on each data-ready interrupt
// reads pitch rate and Z-accel and updates a fused, integrated pitch estimate.
module inert_rdr #(
  parameter int          FAST_SIM       = 1,
  parameter logic [15:0] PTCH_RT_OFFSET = 16'h0050,
  parameter logic [15:0] AZ_OFFSET      = 16'h00A0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        INT,
  input  logic        done,
  input  logic [15:0] resp,
  output logic        snd,
  output logic [15:0] cmd,
  output logic        vld,
  output logic [15:0] ptch,
  output logic [15:0] ptch_rt
);

  typedef enum logic [3:0] {
    S_INIT_WAIT = 4'd0,
    S_INIT1     = 4'd1,
    S_INIT2     = 4'd2,
    S_INIT3     = 4'd3,
    S_INIT4     = 4'd4,
    S_IDLE      = 4'd5,
    S_RD_PL     = 4'd6,
    S_RD_PH     = 4'd7,
    S_RD_AZL    = 4'd8,
    S_RD_AZH    = 4'd9,
    S_UPD       = 4'd10
  } state_t;

  state_t      state_q;
  logic [15:0] tmr_q;
  logic        int_ff1_q, int_ff2_q;
  logic [7:0]  prl_q, prh_q, azl_q, azh_q;
  logic [26:0] integ_q;
  logic [15:0] ptch_q, ptch_rt_q, cmd_q;
  logic        snd_q, vld_q;

  logic               done_ok, tmr_hit, fuse_up_d;
  logic signed [15:0] ptch_rt_d, az_d;
  logic signed [25:0] prod_d, ptch_acc_d;
  logic [26:0]        integ_d;
  logic               resp_hi_unused;

  assign resp_hi_unused = ^resp[15:8];

  // A done coinciding with our own snd cycle cannot belong to this transaction.
  assign done_ok = done & ~snd_q;
  assign tmr_hit = (FAST_SIM != 0) ? (&tmr_q[8:0]) : (&tmr_q);

  always_comb begin
    ptch_rt_d  = $signed({prh_q, prl_q} - PTCH_RT_OFFSET);
    az_d       = $signed({azh_q, azl_q} - AZ_OFFSET);
    prod_d     = $signed({{10{az_d[15]}}, az_d}) * 26'sd327;
    ptch_acc_d = prod_d >>> 13;
    fuse_up_d  = ptch_acc_d > $signed({{10{ptch_q[15]}}, ptch_q});
    integ_d    = integ_q - {{11{ptch_rt_d[15]}}, ptch_rt_d}
               + (fuse_up_d ? 27'd1024 : 27'h7FF_FC00);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_INIT_WAIT;
      tmr_q     <= 16'd0;
      int_ff1_q <= 1'b0;
      int_ff2_q <= 1'b0;
      prl_q     <= 8'd0;
      prh_q     <= 8'd0;
      azl_q     <= 8'd0;
      azh_q     <= 8'd0;
      integ_q   <= 27'd0;
      ptch_q    <= 16'd0;
      ptch_rt_q <= 16'd0;
      cmd_q     <= 16'd0;
      snd_q     <= 1'b0;
      vld_q     <= 1'b0;
    end else begin
      int_ff1_q <= INT;
      int_ff2_q <= int_ff1_q;
      snd_q     <= 1'b0;
      vld_q     <= 1'b0;
      case (state_q)
        S_INIT_WAIT: begin
          tmr_q <= tmr_q + 16'd1;
          if (tmr_hit) begin
            state_q <= S_INIT1;
            snd_q   <= 1'b1;
            cmd_q   <= 16'h0D02;
          end
        end
        S_INIT1: if (done_ok) begin
          state_q <= S_INIT2;
          snd_q   <= 1'b1;
          cmd_q   <= 16'h1053;
        end
        S_INIT2: if (done_ok) begin
          state_q <= S_INIT3;
          snd_q   <= 1'b1;
          cmd_q   <= 16'h1150;
        end
        S_INIT3: if (done_ok) begin
          state_q <= S_INIT4;
          snd_q   <= 1'b1;
          cmd_q   <= 16'h1460;
        end
        S_INIT4: if (done_ok) state_q <= S_IDLE;
        S_IDLE: if (int_ff2_q) begin
          state_q <= S_RD_PL;
          snd_q   <= 1'b1;
          cmd_q   <= 16'hA200;
        end
        S_RD_PL: if (done_ok) begin
          prl_q   <= resp[7:0];
          state_q <= S_RD_PH;
          snd_q   <= 1'b1;
          cmd_q   <= 16'hA300;
        end
        S_RD_PH: if (done_ok) begin
          prh_q   <= resp[7:0];
          state_q <= S_RD_AZL;
          snd_q   <= 1'b1;
          cmd_q   <= 16'hAC00;
        end
        S_RD_AZL: if (done_ok) begin
          azl_q   <= resp[7:0];
          state_q <= S_RD_AZH;
          snd_q   <= 1'b1;
          cmd_q   <= 16'hAD00;
        end
        S_RD_AZH: if (done_ok) begin
          azh_q   <= resp[7:0];
          state_q <= S_UPD;
        end
        S_UPD: begin
          integ_q   <= integ_d;
          ptch_q    <= integ_d[26:11];
          ptch_rt_q <= ptch_rt_d;
          vld_q     <= 1'b1;
          state_q   <= S_IDLE;
        end
        default: state_q <= S_INIT_WAIT;
      endcase
    end
  end

  assign snd     = snd_q;
  assign cmd     = cmd_q;
  assign vld     = vld_q;
  assign ptch    = ptch_q;
  assign ptch_rt = ptch_rt_q;

endmodule
`default_nettype wire

// File: tb/tb_inert_rdr.sv
`default_nettype none
// tb_inert_rdr: directed sequence with randomized SPI timing/data against a pitch model.
module tb_inert_rdr;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        irq = 1'b0;
  logic        done = 1'b0;
  logic [15:0] resp = 16'd0;
  logic        snd, vld;
  logic [15:0] cmd, ptch, ptch_rt;

  inert_rdr #(.FAST_SIM(1), .PTCH_RT_OFFSET(16'h0050), .AZ_OFFSET(16'h00A0)) dut (
    .clk(clk), .rst(rst), .INT(irq), .done(done), .resp(resp),
    .snd(snd), .cmd(cmd), .vld(vld), .ptch(ptch), .ptch_rt(ptch_rt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int proto_viol = 0;
  int stray_vld = 0;

  logic [26:0]        m_integ = 27'd0;
  logic signed [15:0] m_ptch = 16'sd0;
  logic signed [15:0] m_rt = 16'sd0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
    if (vld) stray_vld++;
  endtask

  // Reference: pitch filter from raw bytes, in plain integer arithmetic.
  function automatic void model_upd(input logic [7:0] pl, ph, al, ah);
    int raw_rt, raw_az, rt, az, acc, fus, tmp;
    raw_rt = int'({ph, pl});
    raw_az = int'({ah, al});
    rt = raw_rt - 'h50;
    if (rt < -32768) rt += 65536;
    az = raw_az - 'hA0;
    if (az > 32767) az -= 65536;
    if (az < -32768) az += 65536;
    if (rt > 32767) rt -= 65536;
    acc = (az * 327) >>> 13;
    fus = (acc > int'(m_ptch)) ? 1024 : -1024;
    tmp = int'(m_integ) - rt + fus;
    m_integ = tmp[26:0];
    m_ptch = m_integ[26:11];
    m_rt = rt[15:0];
  endfunction

  task automatic model_reset();
    m_integ = 27'd0;
    m_ptch = 16'sd0;
    m_rt = 16'sd0;
  endtask

  task automatic wait_init(input string tag);
    int n = 0;
    while (!snd && n < 600) begin tick(); n++; end
    chk(tag, n, 512);
  endtask

  task automatic do_txn(input logic [15:0] exp, input logic [7:0] rbyte, input bit drop);
    int n = 0;
    int lat;
    while (!snd && n < 64) begin tick(); n++; end
    chk("snd_seen", {31'd0, snd}, 32'd1);
    if (!snd) return;
    chk("cmd", {16'd0, cmd}, {16'd0, exp});
    lat = $urandom_range(1, 3);
    repeat (lat) begin
      tick();
      if (snd || cmd !== exp) proto_viol++;
    end
    done = 1'b1;
    resp = {8'($urandom), rbyte};
    if (drop) irq = 1'b0;
    tick();
    done = 1'b0;
    resp = 16'($urandom);
  endtask

  task automatic init_seq();
    do_txn(16'h0D02, 8'($urandom), 1'b0);
    do_txn(16'h1053, 8'($urandom), 1'b0);
    do_txn(16'h1150, 8'($urandom), 1'b0);
    do_txn(16'h1460, 8'($urandom), 1'b0);
  endtask

  task automatic do_read(input logic [7:0] pl, ph, al, ah, input bit drop);
    do_txn(16'hA200, pl, 1'b0);
    do_txn(16'hA300, ph, 1'b0);
    do_txn(16'hAC00, al, 1'b0);
    do_txn(16'hAD00, ah, drop);
    model_upd(pl, ph, al, ah);
    chk("vld_early", {31'd0, vld}, 32'd0);
    @(posedge clk); #1;
    chk("vld", {31'd0, vld}, 32'd1);
    chk("ptch_rt", {16'd0, ptch_rt}, {16'd0, m_rt});
    chk("ptch", {16'd0, ptch}, {16'd0, m_ptch});
    @(posedge clk); #1;
    chk("vld_width", {31'd0, vld}, 32'd0);
  endtask

  initial begin
    int snds;
    int n;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_snd", {31'd0, snd}, 32'd0);
    chk("rst_vld", {31'd0, vld}, 32'd0);
    chk("rst_cmd", {16'd0, cmd}, 32'd0);
    chk("rst_ptch", {16'd0, ptch}, 32'd0);
    chk("rst_ptch_rt", {16'd0, ptch_rt}, 32'd0);
    rst = 1'b0;
    wait_init("init_delay");
    init_seq();

    snds = 0;
    repeat (10000) begin
      tick();
      if (snd) snds++;
    end
    chk("idle_snd", snds, 0);

    repeat (3) begin
      irq = 1'b1;
      do_read(8'h50, 8'h00, 8'hA0, 8'h00, 1'b1);
    end

    repeat (100) begin
      irq = 1'b1;
      do_read(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 1'b1);
      repeat ($urandom_range(0, 5)) begin
        tick();
        if (snd) proto_viol++;
      end
    end

    irq = 1'b1;
    for (int i = 0; i < 2048; i++)
      do_read(8'h50, 8'h01, 8'hA0, 8'h00, (i == 2047));
    chk("rate_0150", {16'd0, ptch_rt}, 32'h0000_0100);

    irq = 1'b1;
    do_txn(16'hA200, 8'($urandom), 1'b0);
    tick();
    irq = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_snd", {31'd0, snd}, 32'd0);
    chk("mid_rst_ptch", {16'd0, ptch}, 32'd0);
    chk("mid_rst_ptch_rt", {16'd0, ptch_rt}, 32'd0);
    rst = 1'b0;
    model_reset();
    n = 0;
    while (!snd && n < 600) begin
      if (n == 3) begin
        done = 1'b1;
        resp = 16'h00FF;
      end else begin
        done = 1'b0;
      end
      tick();
      n++;
    end
    done = 1'b0;
    chk("reinit_delay", n, 512);
    chk("reinit_cmd", {16'd0, cmd}, 32'h0000_0D02);
    init_seq();
    chk("post_rst_ptch", {16'd0, ptch}, 32'd0);
    irq = 1'b1;
    do_read(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 1'b1);

    chk("stray_vld", stray_vld, 0);
    chk("protocol", proto_viol, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
